// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR block for the RV32 core.
// Holds mstatus/mie/mtvec/mepc/mcause/mip plus wide mcycle/minstret
// counters, arbitrates level interrupts, performs trap entry and MRET
// return, sleeps on WFI and drives a one-cycle PC redirect into fetch.
// Optional feature macro: VECTORED_MTVEC_EN (mtvec[0] becomes MODE;
// MODE=1 sends interrupts to base + 4*code).
module csr_trap_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     CNT_W       = 64,
   parameter int unsigned     NUM_IRQ     = 2,
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h00010000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [11:0]        csr_raddr,
   output logic [XLEN-1:0]    csr_rdata,
   output logic               csr_illegal,
   input  logic               csr_we,
   input  logic [11:0]        csr_waddr,
   input  logic [1:0]         csr_op,
   input  logic [XLEN-1:0]    csr_wdata,
   input  logic               retire,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic               irq_allow,
   input  logic [XLEN-1:0]    pc_i,
   input  logic               mret,
   input  logic               wfi,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               sleeping
);

   typedef enum logic [1:0] {
      RUN,
      SLEEP,
      REDIR
   } state_e;

   typedef enum logic [3:0] {
      SEL_MSTATUS  = 4'd0,
      SEL_MIE      = 4'd1,
      SEL_MTVEC    = 4'd2,
      SEL_MEPC     = 4'd3,
      SEL_MCAUSE   = 4'd4,
      SEL_MIP      = 4'd5,
      SEL_MCYCLE   = 4'd6,
      SEL_MINSTRET = 4'd7,
      SEL_MCYCLEH  = 4'd8,
      SEL_MINSTRH  = 4'd9,
      SEL_NONE     = 4'd15
   } csr_sel_e;

   // Bit position in mip/mie for interrupt input k
   function automatic int unsigned irq_pos(input int unsigned k);
      if (k == 0)      return 11;
      else if (k == 1) return 7;
      else             return 16 + k - 2;
   endfunction

   function automatic logic [XLEN-1:0] irq_mask_f();
      logic [XLEN-1:0] m;
      m = '0;
      for (int unsigned k = 0; k < NUM_IRQ; k++) m[irq_pos(k)] = 1'b1;
      return m;
   endfunction

   function automatic csr_sel_e decode(input logic [11:0] a);
      case (a)
         12'h300: return SEL_MSTATUS;
         12'h304: return SEL_MIE;
         12'h305: return SEL_MTVEC;
         12'h341: return SEL_MEPC;
         12'h342: return SEL_MCAUSE;
         12'h344: return SEL_MIP;
         12'hB00: return SEL_MCYCLE;
         12'hB02: return SEL_MINSTRET;
         12'hB80: return SEL_MCYCLEH;
         12'hB82: return SEL_MINSTRH;
         default: return SEL_NONE;
      endcase
   endfunction

   localparam logic [XLEN-1:0] IRQ_MASK      = irq_mask_f();
   localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(32'h0000_0088);
   localparam logic [XLEN-1:0] MEPC_WMASK    = ~XLEN'(3);
`ifdef VECTORED_MTVEC_EN
   localparam logic [XLEN-1:0] MTVEC_WMASK   = ~XLEN'(2);
`else
   localparam logic [XLEN-1:0] MTVEC_WMASK   = ~XLEN'(3);
`endif
   localparam logic [XLEN-1:0] CNTH_WMASK    = {XLEN{1'b1}} >> (2 * XLEN - CNT_W);

   // Architectural state
   state_e            state;
   logic              ms_mie_q;
   logic              ms_mpie_q;
   logic [XLEN-1:0]   mie_q;
   logic [XLEN-1:0]   mip_q;
   logic [XLEN-1:0]   mtvec_q;
   logic [XLEN-1:0]   mepc_q;
   logic [XLEN-1:0]   mcause_q;
   logic [CNT_W-1:0]  mcycle_q;
   logic [CNT_W-1:0]  minstret_q;

   // Combinational helpers
   logic [XLEN-1:0]   irq_vec;
   logic [XLEN-1:0]   pend_bits;
   logic              pend;
   logic [4:0]        irq_code;
   logic [2*XLEN-1:0] cyc_ext;
   logic [2*XLEN-1:0] ins_ext;
   logic [XLEN-1:0]   img   [16];
   logic [XLEN-1:0]   wmask [16];
   csr_sel_e          rsel;
   csr_sel_e          wsel;
   logic              w_en;
   logic [XLEN-1:0]   w_old;
   logic [XLEN-1:0]   w_raw;
   logic [XLEN-1:0]   w_new;
   logic              ms_mie_w;
   logic              ms_mpie_w;
   logic [XLEN-1:0]   mie_w;
   logic [XLEN-1:0]   mtvec_w;
   logic [XLEN-1:0]   mepc_w;
   logic [XLEN-1:0]   mcause_w;
   logic [2*XLEN-1:0] cyc_tmp;
   logic [2*XLEN-1:0] ins_tmp;
   logic [CNT_W-1:0]  mcycle_n;
   logic [CNT_W-1:0]  minstret_n;
   logic              take;
   logic              do_mret;
   logic              do_wfi;
   logic [XLEN-1:0]   tvec_base;
   logic [XLEN-1:0]   trap_pc;
   logic [XLEN-1:0]   cause_val;

   // Map interrupt inputs onto their mip bit positions
   always_comb begin
      irq_vec = '0;
      for (int unsigned k = 0; k < NUM_IRQ; k++) irq_vec[irq_pos(k)] = irq_i[k];
   end

   // Pending set and highest-priority cause (lower input index wins)
   always_comb begin
      pend_bits = mip_q & mie_q;
      pend      = |pend_bits;
      irq_code  = '0;
      for (int unsigned j = 0; j < NUM_IRQ; j++) begin
         if (pend_bits[irq_pos(NUM_IRQ - 1 - j)]) irq_code = 5'(irq_pos(NUM_IRQ - 1 - j));
      end
   end

   // Read image of every CSR and its writable-bit mask
   always_comb begin
      for (int unsigned i = 0; i < 16; i++) begin
         img[i]   = '0;
         wmask[i] = '0;
      end
      cyc_ext = '0;
      cyc_ext[CNT_W-1:0] = mcycle_q;
      ins_ext = '0;
      ins_ext[CNT_W-1:0] = minstret_q;

      img[SEL_MSTATUS][12:11] = 2'b11;
      img[SEL_MSTATUS][7]     = ms_mpie_q;
      img[SEL_MSTATUS][3]     = ms_mie_q;
      img[SEL_MIE]            = mie_q;
      img[SEL_MTVEC]          = mtvec_q;
      img[SEL_MEPC]           = mepc_q;
      img[SEL_MCAUSE]         = mcause_q;
      img[SEL_MIP]            = mip_q;
      img[SEL_MCYCLE]         = cyc_ext[XLEN-1:0];
      img[SEL_MINSTRET]       = ins_ext[XLEN-1:0];
      img[SEL_MCYCLEH]        = cyc_ext[2*XLEN-1:XLEN];
      img[SEL_MINSTRH]        = ins_ext[2*XLEN-1:XLEN];

      wmask[SEL_MSTATUS]  = MSTATUS_WMASK;
      wmask[SEL_MIE]      = IRQ_MASK;
      wmask[SEL_MTVEC]    = MTVEC_WMASK;
      wmask[SEL_MEPC]     = MEPC_WMASK;
      wmask[SEL_MCAUSE]   = '1;
      wmask[SEL_MCYCLE]   = '1;
      wmask[SEL_MINSTRET] = '1;
      wmask[SEL_MCYCLEH]  = CNTH_WMASK;
      wmask[SEL_MINSTRH]  = CNTH_WMASK;
   end

   // Write-value computation, read mux and same-address bypass
   always_comb begin
      rsel  = decode(csr_raddr);
      wsel  = decode(csr_waddr);
      w_en  = csr_we && (wsel != SEL_NONE);
      w_old = img[wsel];
      case (csr_op)
         2'b00:   w_raw = csr_wdata;
         2'b01:   w_raw = w_old | csr_wdata;
         2'b10:   w_raw = w_old & ~csr_wdata;
         default: w_raw = w_old;
      endcase
      w_new       = (w_old & ~wmask[wsel]) | (w_raw & wmask[wsel]);
      csr_illegal = (rsel == SEL_NONE);
      csr_rdata   = (csr_we && (csr_waddr == csr_raddr)) ? w_new : img[rsel];
   end

   // Post-write register values and counter next state
   always_comb begin
      ms_mie_w  = (w_en && wsel == SEL_MSTATUS) ? w_new[3] : ms_mie_q;
      ms_mpie_w = (w_en && wsel == SEL_MSTATUS) ? w_new[7] : ms_mpie_q;
      mie_w     = (w_en && wsel == SEL_MIE)     ? w_new    : mie_q;
      mtvec_w   = (w_en && wsel == SEL_MTVEC)   ? w_new    : mtvec_q;
      mepc_w    = (w_en && wsel == SEL_MEPC)    ? w_new    : mepc_q;
      mcause_w  = (w_en && wsel == SEL_MCAUSE)  ? w_new    : mcause_q;

      cyc_tmp  = cyc_ext;
      ins_tmp  = ins_ext;
      mcycle_n = mcycle_q + CNT_W'(1);
      if (w_en && wsel == SEL_MCYCLE) begin
         cyc_tmp[XLEN-1:0] = w_new;
         mcycle_n = cyc_tmp[CNT_W-1:0];
      end else if (w_en && wsel == SEL_MCYCLEH) begin
         cyc_tmp[2*XLEN-1:XLEN] = w_new;
         mcycle_n = cyc_tmp[CNT_W-1:0];
      end
      minstret_n = retire ? minstret_q + CNT_W'(1) : minstret_q;
      if (w_en && wsel == SEL_MINSTRET) begin
         ins_tmp[XLEN-1:0] = w_new;
         minstret_n = ins_tmp[CNT_W-1:0];
      end else if (w_en && wsel == SEL_MINSTRH) begin
         ins_tmp[2*XLEN-1:XLEN] = w_new;
         minstret_n = ins_tmp[CNT_W-1:0];
      end
   end

   // Trap/MRET/WFI decisions and trap target
   always_comb begin
      take      = (state == RUN) && ms_mie_q && pend && irq_allow && !mret;
      do_mret   = (state == RUN) && mret;
      do_wfi    = (state == RUN) && wfi && !mret && !pend;
      tvec_base = {mtvec_w[XLEN-1:2], 2'b00};
`ifdef VECTORED_MTVEC_EN
      trap_pc   = mtvec_w[0] ? tvec_base + (XLEN'(irq_code) << 2) : tvec_base;
`else
      trap_pc   = tvec_base;
`endif
      cause_val          = '0;
      cause_val[XLEN-1]  = 1'b1;
      cause_val[4:0]     = irq_code;
   end

   // CSR and counter registers; a same-cycle CSR write lands first and the
   // trap/MRET field updates are layered on top of the post-write values
   always_ff @(posedge clk) begin
      if (!rst) begin
         ms_mie_q   <= 1'b0;
         ms_mpie_q  <= 1'b0;
         mie_q      <= '0;
         mip_q      <= '0;
         mtvec_q    <= MTVEC_RESET & MTVEC_WMASK;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mip_q      <= irq_vec;
         mie_q      <= mie_w;
         mtvec_q    <= mtvec_w;
         mepc_q     <= mepc_w;
         mcause_q   <= mcause_w;
         ms_mie_q   <= ms_mie_w;
         ms_mpie_q  <= ms_mpie_w;
         mcycle_q   <= mcycle_n;
         minstret_q <= minstret_n;
         if (take) begin
            mepc_q    <= pc_i & MEPC_WMASK;
            mcause_q  <= cause_val;
            ms_mpie_q <= ms_mie_w;
            ms_mie_q  <= 1'b0;
         end else if (do_mret) begin
            ms_mie_q  <= ms_mpie_w;
            ms_mpie_q <= 1'b1;
         end
      end
   end

   // Control FSM with registered redirect and sleep outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= RUN;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         sleeping       <= 1'b0;
      end else begin
         redirect_valid <= 1'b0;
         case (state)
            RUN: begin
               if (do_mret) begin
                  state          <= REDIR;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= mepc_w;
               end else if (take) begin
                  state          <= REDIR;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= trap_pc;
               end else if (do_wfi) begin
                  state    <= SLEEP;
                  sleeping <= 1'b1;
               end
            end
            SLEEP: begin
               if (pend) begin
                  state    <= RUN;
                  sleeping <= 1'b0;
               end
            end
            REDIR: begin
               state <= RUN;
            end
            default: begin
               state    <= RUN;
               sleeping <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: table of CSR read/write vectors plus
// hand-written sequences for traps, MRET, WFI, counters and reset aborts.
`timescale 1ns/1ps
module tb_csr_trap_unit;
   localparam int unsigned XLEN    = 32;
   localparam int unsigned CNT_W   = 64;
   localparam int unsigned NUM_IRQ = 2;

   logic               clk;
   logic               rst;
   logic [11:0]        csr_raddr;
   logic [XLEN-1:0]    csr_rdata;
   logic               csr_illegal;
   logic               csr_we;
   logic [11:0]        csr_waddr;
   logic [1:0]         csr_op;
   logic [XLEN-1:0]    csr_wdata;
   logic               retire;
   logic [NUM_IRQ-1:0] irq_i;
   logic               irq_allow;
   logic [XLEN-1:0]    pc_i;
   logic               mret;
   logic               wfi;
   logic               redirect_valid;
   logic [XLEN-1:0]    redirect_pc;
   logic               sleeping;

   csr_trap_unit #(
      .XLEN(XLEN),
      .CNT_W(CNT_W),
      .NUM_IRQ(NUM_IRQ),
      .MTVEC_RESET(32'h00010000)
   ) dut (
      .clk(clk), .rst(rst),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_op(csr_op), .csr_wdata(csr_wdata),
      .retire(retire), .irq_i(irq_i), .irq_allow(irq_allow), .pc_i(pc_i),
      .mret(mret), .wfi(wfi),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .sleeping(sleeping)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        we;
      logic [11:0] waddr;
      logic [1:0]  op;
      logic [31:0] wdata;
      logic [11:0] raddr;
      logic [31:0] exp;
      logic        ill;
   } vec_t;

   vec_t vecs [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr_raddr = a;
      #1;
      check(name, csr_rdata, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      csr_we    = 1'b1;
      csr_waddr = a;
      csr_op    = op;
      csr_wdata = d;
      tick;
      csr_we    = 1'b0;
   endtask

   logic [31:0] mtvec_wr_exp;
   logic [31:0] vec_pc_exp;

   initial begin
`ifdef VECTORED_MTVEC_EN
      mtvec_wr_exp = 32'h12345675;
      vec_pc_exp   = 32'h0001002C;
`else
      mtvec_wr_exp = 32'h12345674;
      vec_pc_exp   = 32'h00010000;
`endif
      //            we    waddr    op     wdata          raddr    expected      ill
      vecs[0]  = '{1'b0, 12'h000, 2'b11, 32'h00000000, 12'h305, 32'h00010000, 1'b0};
      vecs[1]  = '{1'b0, 12'h000, 2'b11, 32'h00000000, 12'h300, 32'h00001800, 1'b0};
      vecs[2]  = '{1'b1, 12'h300, 2'b00, 32'hFFFFFFFF, 12'h300, 32'h00001888, 1'b0};
      vecs[3]  = '{1'b0, 12'h000, 2'b11, 32'h00000000, 12'h300, 32'h00001888, 1'b0};
      vecs[4]  = '{1'b1, 12'h300, 2'b10, 32'h00000080, 12'h300, 32'h00001808, 1'b0};
      vecs[5]  = '{1'b1, 12'h304, 2'b00, 32'hFFFFFFFF, 12'h304, 32'h00000880, 1'b0};
      vecs[6]  = '{1'b1, 12'h305, 2'b00, 32'h12345677, 12'h305, mtvec_wr_exp, 1'b0};
      vecs[7]  = '{1'b0, 12'h000, 2'b11, 32'h00000000, 12'h305, mtvec_wr_exp, 1'b0};
      vecs[8]  = '{1'b1, 12'h341, 2'b00, 32'h00000103, 12'h341, 32'h00000100, 1'b0};
      vecs[9]  = '{1'b1, 12'h342, 2'b01, 32'h80000005, 12'h342, 32'h80000005, 1'b0};
      vecs[10] = '{1'b1, 12'h344, 2'b00, 32'hFFFFFFFF, 12'h344, 32'h00000000, 1'b0};
      vecs[11] = '{1'b0, 12'h000, 2'b11, 32'h00000000, 12'h123, 32'h00000000, 1'b1};
      vecs[12] = '{1'b1, 12'h123, 2'b00, 32'hFFFFFFFF, 12'h123, 32'h00000000, 1'b1};
      vecs[13] = '{1'b1, 12'h304, 2'b11, 32'hFFFFFFFF, 12'h304, 32'h00000880, 1'b0};
      vecs[14] = '{1'b1, 12'h304, 2'b10, 32'h00000800, 12'h304, 32'h00000080, 1'b0};
      vecs[15] = '{1'b1, 12'h341, 2'b00, 32'h00000200, 12'h305, mtvec_wr_exp, 1'b0};
      vecs[16] = '{1'b0, 12'h000, 2'b11, 32'h00000000, 12'h341, 32'h00000200, 1'b0};
      vecs[17] = '{1'b1, 12'h305, 2'b00, 32'h00010000, 12'h305, 32'h00010000, 1'b0};
      vecs[18] = '{1'b0, 12'h000, 2'b11, 32'h00000000, 12'hB02, 32'h00000000, 1'b0};
      vecs[19] = '{1'b0, 12'h000, 2'b11, 32'h00000000, 12'hB82, 32'h00000000, 1'b0};
      vecs[20] = '{1'b1, 12'h300, 2'b00, 32'h00000000, 12'h300, 32'h00001800, 1'b0};
      vecs[21] = '{1'b0, 12'h000, 2'b11, 32'h00000000, 12'hB80, 32'h00000000, 1'b0};

      rst = 1'b0; csr_raddr = 12'h300; csr_we = 1'b0; csr_waddr = 12'h000;
      csr_op = 2'b11; csr_wdata = '0; retire = 1'b0; irq_i = '0; irq_allow = 1'b0;
      pc_i = '0; mret = 1'b0; wfi = 1'b0;

      // Reset state and counter start
      tick; tick; tick;
      chk_csr("reset mcycle", 12'hB00, 32'h0);
      check1("reset redirect_valid", redirect_valid, 1'b0);
      check1("reset sleeping", sleeping, 1'b0);
      rst = 1'b1;
      repeat (10) tick;
      chk_csr("mcycle after 10", 12'hB00, 32'd10);
      chk_csr("minstret idle", 12'hB02, 32'h0);
      chk_csr("reset mtvec", 12'h305, 32'h00010000);
      chk_csr("reset mstatus", 12'h300, 32'h00001800);

      // Table-driven CSR access vectors
      for (int i = 0; i < 22; i++) begin
         csr_we    = vecs[i].we;
         csr_waddr = vecs[i].waddr;
         csr_op    = vecs[i].op;
         csr_wdata = vecs[i].wdata;
         csr_raddr = vecs[i].raddr;
         #1;
         check($sformatf("vec%0d rdata", i), csr_rdata, vecs[i].exp);
         check1($sformatf("vec%0d illegal", i), csr_illegal, vecs[i].ill);
         tick;
      end
      csr_we = 1'b0;

      // Interrupt trap entry
      wr(12'h300, 2'b00, 32'h8);
      wr(12'h304, 2'b00, 32'h800);
      pc_i = 32'h100; irq_allow = 1'b1; irq_i = 2'b01;
      tick;
      check1("trap no early pulse", redirect_valid, 1'b0);
      tick;
      check1("trap pulse", redirect_valid, 1'b1);
      check("trap pc", redirect_pc, 32'h00010000);
      irq_i = 2'b00;
      tick;
      check1("trap pulse one cycle", redirect_valid, 1'b0);
      chk_csr("trap mepc", 12'h341, 32'h100);
      chk_csr("trap mcause", 12'h342, 32'h8000000B);
      chk_csr("trap mstatus", 12'h300, 32'h00001880);

      // MRET return
      mret = 1'b1;
      tick;
      mret = 1'b0;
      check1("mret pulse", redirect_valid, 1'b1);
      check("mret pc", redirect_pc, 32'h100);
      chk_csr("mret mstatus", 12'h300, 32'h00001888);

      // MRET racing a pending interrupt: MRET first, trap after REDIR
      irq_allow = 1'b0; irq_i = 2'b10;
      wr(12'h304, 2'b00, 32'h880);
      mret = 1'b1; irq_allow = 1'b1;
      tick;
      mret = 1'b0;
      check1("race mret pulse", redirect_valid, 1'b1);
      check("race mret pc", redirect_pc, 32'h100);
      chk_csr("race mcause unchanged", 12'h342, 32'h8000000B);
      tick;
      check1("race redir gap", redirect_valid, 1'b0);
      tick;
      check1("race trap pulse", redirect_valid, 1'b1);
      check("race trap pc", redirect_pc, 32'h00010000);
      chk_csr("race mcause MTIP", 12'h342, 32'h80000007);
      irq_i = 2'b00; irq_allow = 1'b0;
      tick;
      check1("race pulse end", redirect_valid, 1'b0);
      chk_csr("race mstatus", 12'h300, 32'h00001880);

      // Counter half writes and wrap
      wr(12'hB00, 2'b00, 32'hFFFFFFFF);
      wr(12'hB80, 2'b00, 32'h0);
      chk_csr("mcycle hold on hi write", 12'hB00, 32'hFFFFFFFF);
      chk_csr("mcycleh written", 12'hB80, 32'h0);
      tick;
      chk_csr("mcycle carry lo", 12'hB00, 32'h0);
      chk_csr("mcycle carry hi", 12'hB80, 32'h1);
      wr(12'hB80, 2'b00, 32'h7);
      chk_csr("mcycleh write", 12'hB80, 32'h7);
      chk_csr("mcycle no inc on write", 12'hB00, 32'h0);
      retire = 1'b1;
      wr(12'hB02, 2'b00, 32'h5);
      chk_csr("minstret write drops inc", 12'hB02, 32'h5);
      tick;
      chk_csr("minstret retire", 12'hB02, 32'h6);
      retire = 1'b0;
      tick;
      chk_csr("minstret idle hold", 12'hB02, 32'h6);
      wr(12'hB82, 2'b00, 32'hFFFFFFFF);
      wr(12'hB02, 2'b00, 32'hFFFFFFFF);
      retire = 1'b1;
      tick;
      retire = 1'b0;
      chk_csr("minstret wrap lo", 12'hB02, 32'h0);
      chk_csr("minstret wrap hi", 12'hB82, 32'h0);

      // Same-address write bypass
      csr_raddr = 12'h300; csr_we = 1'b1; csr_waddr = 12'h300;
      csr_op = 2'b01; csr_wdata = 32'h8;
      #1;
      check("bypass set MIE", csr_rdata, 32'h00001888);
      tick;
      csr_we = 1'b0;
      chk_csr("bypass stored", 12'h300, 32'h00001888);

      // WFI sleep and wake without trap
      wr(12'h300, 2'b10, 32'h8);
      wr(12'h304, 2'b00, 32'h80);
      irq_allow = 1'b1;
      wfi = 1'b1;
      tick;
      wfi = 1'b0;
      check1("wfi sleeping", sleeping, 1'b1);
      tick;
      check1("wfi stays asleep", sleeping, 1'b1);
      irq_i = 2'b10;
      tick;
      chk_csr("wfi mip latched", 12'h344, 32'h80);
      check1("wfi still asleep", sleeping, 1'b1);
      tick;
      check1("wfi woke", sleeping, 1'b0);
      check1("wfi wake no redirect", redirect_valid, 1'b0);
      tick;
      check1("wfi no trap MIE=0", redirect_valid, 1'b0);
      wfi = 1'b1;
      tick;
      wfi = 1'b0;
      check1("wfi with pend no-op", sleeping, 1'b0);

      // Reset aborts SLEEP
      irq_i = 2'b00;
      tick;
      wfi = 1'b1;
      tick;
      wfi = 1'b0;
      check1("sleep before reset", sleeping, 1'b1);
      rst = 1'b0;
      tick;
      rst = 1'b1;
      check1("reset clears sleeping", sleeping, 1'b0);

      // Trap target (vectored when enabled) and reset aborting REDIR
`ifdef VECTORED_MTVEC_EN
      wr(12'h305, 2'b00, 32'h00010001);
`endif
      wr(12'h300, 2'b00, 32'h8);
      wr(12'h304, 2'b00, 32'h800);
      pc_i = 32'h240; irq_i = 2'b01; irq_allow = 1'b1;
      tick;
      tick;
      check1("vec trap pulse", redirect_valid, 1'b1);
      check("vec trap pc", redirect_pc, vec_pc_exp);
      rst = 1'b0;
      tick;
      rst = 1'b1; irq_i = 2'b00; irq_allow = 1'b0;
      check1("reset aborts redir", redirect_valid, 1'b0);
      check1("reset redir sleeping", sleeping, 1'b0);
      chk_csr("post-reset mcycle", 12'hB00, 32'h0);
      chk_csr("post-reset mstatus", 12'h300, 32'h00001800);
      chk_csr("post-reset mtvec", 12'h305, 32'h00010000);
      chk_csr("post-reset mepc", 12'h341, 32'h0);
      chk_csr("post-reset mcause", 12'h342, 32'h0);
      tick;
      check1("post-reset no pulse", redirect_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
